machine_scheduler: RTL and testbench

Dispatches a stream of Day 10 machine descriptors across `NUM_WORKERS` parallel `configure_machine` instances. It also sums each worker's `min_button_presses` into a puzzle total. The block sits between the descriptor parser and the worker array. It owns every worker's `start`/`accepted` handshake and the load strobe of each per-worker descriptor register. It never touches descriptor data itself.

---
 rtl/day10_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/machine_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_machine_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day10_sched_pkg.sv
// Shared types and width helpers for the Day 10 machine scheduler.
package day10_sched_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        SL_IDLE,
        SL_START,
        SL_BUSY,
        SL_COOL
    } slot_state_t;

    // Index width for n slots; a single slot still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_WORKERS = 4;
    localparam int SLOT_IDX_W          = idx_width(DEFAULT_NUM_WORKERS);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner when advanced.
module rr_arbiter
    import day10_sched_pkg::*;
#(
    parameter  int N     = 4,
    localparam int PTR_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_winIdx;
    logic             w_found;
    int               w_j;

    // Scan requesters starting at the pointer, wrapping once around.
    always_comb begin
        o_grant  = '0;
        w_winIdx = '0;
        w_found  = 1'b0;
        w_j      = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && i_req[w_j]) begin
                w_found     = 1'b1;
                o_grant[w_j] = 1'b1;
                w_winIdx    = PTR_W'(w_j);
            end
        end
    end

    // Pointer moves past the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            if (int'(w_winIdx) == N - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_winIdx + PTR_W'(1);
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/machine_scheduler.sv
// Dispatches machine descriptors across a worker array and accumulates
// each worker's minimum button-press count into a stream total.
module machine_scheduler
    import day10_sched_pkg::*;
#(
    parameter int NUM_WORKERS       = 4,
    parameter int MAX_NUM_PRESSES_W = 4,
    parameter int SUM_W             = 16,
    parameter int JOB_CNT_W         = 12
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   job_valid,
    input  logic                                   job_last,
    output logic                                   job_ready,
    output logic [NUM_WORKERS-1:0]                 worker_load,
    output logic [NUM_WORKERS-1:0]                 worker_start,
    input  logic [NUM_WORKERS-1:0]                 worker_ready,
    input  logic [NUM_WORKERS*MAX_NUM_PRESSES_W-1:0] worker_presses,
    output logic [NUM_WORKERS-1:0]                 worker_accepted,
    input  logic                                   clear,
    output logic [SUM_W-1:0]                       total,
    output logic                                   done
);

    localparam int IDX_W = idx_width(NUM_WORKERS);

    sched_state_t r_state;
    sched_state_t w_stateNext;
    slot_state_t  r_slot     [NUM_WORKERS];
    slot_state_t  w_slotNext [NUM_WORKERS];

    logic [NUM_WORKERS-1:0]       r_start;
    logic [NUM_WORKERS-1:0]       r_accepted;
    logic [SUM_W-1:0]             r_total;
    logic [JOB_CNT_W-1:0]         r_issued;
    logic [JOB_CNT_W-1:0]         r_retired;

    logic [SUM_W-1:0]             w_totalNext;
    logic [JOB_CNT_W-1:0]         w_issuedNext;
    logic [JOB_CNT_W-1:0]         w_retiredNext;

    logic [NUM_WORKERS-1:0]       w_idle;
    logic [NUM_WORKERS-1:0]       w_busy;
    logic [NUM_WORKERS-1:0]       w_active;
    logic [NUM_WORKERS-1:0]       w_loadSel;
    logic                         w_seenIdle;
    logic                         w_fire;
    logic [NUM_WORKERS-1:0]       w_retireReq;
    logic [NUM_WORKERS-1:0]       w_retireGrant;
    logic                         w_retireAdvance;
    logic                         w_retire;
    logic [MAX_NUM_PRESSES_W-1:0] w_retirePresses;
    logic [IDX_W-1:0]             w_unusedRrPtr;

    // Decode per-slot state into idle/busy/in-flight masks.
    always_comb begin
        w_idle   = '0;
        w_busy   = '0;
        w_active = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            w_idle[i]   = (r_slot[i] == SL_IDLE);
            w_busy[i]   = (r_slot[i] == SL_BUSY);
            w_active[i] = (r_slot[i] == SL_START) || (r_slot[i] == SL_BUSY);
        end
    end

    // Lowest-index idle slot receives the next descriptor.
    always_comb begin
        w_loadSel  = '0;
        w_seenIdle = 1'b0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (!w_seenIdle && w_idle[i]) begin
                w_loadSel[i] = 1'b1;
                w_seenIdle   = 1'b1;
            end
        end
    end

    assign job_ready   = (r_state == S_RUN) && (|w_idle);
    assign w_fire      = job_valid && job_ready;
    assign worker_load = w_fire ? w_loadSel : '0;

    // A slot whose accept pulse is already out must not be granted again
    // while its worker's ready is still visible.
    assign w_retireReq     = w_busy & worker_ready & ~r_accepted;
    assign w_retireAdvance = |w_retireReq;

    rr_arbiter #(
        .N (NUM_WORKERS)
    ) u_retireArb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_retireReq),
        .i_advance (w_retireAdvance),
        .o_grant   (w_retireGrant),
        .o_ptr     (w_unusedRrPtr)
    );

    // Select the press count of the slot whose accept pulse is out now.
    always_comb begin
        w_retirePresses = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (r_accepted[i]) begin
                w_retirePresses |= worker_presses[i*MAX_NUM_PRESSES_W +: MAX_NUM_PRESSES_W];
            end
        end
    end

    assign w_retire = |r_accepted;

    // Next-state for the global FSM, the slots, the total and the counters.
    always_comb begin
        w_stateNext   = r_state;
        w_totalNext   = r_total + (w_retire ? SUM_W'(w_retirePresses) : '0);
        w_issuedNext  = r_issued + JOB_CNT_W'(w_fire);
        w_retiredNext = r_retired + JOB_CNT_W'(w_retire);

        for (int i = 0; i < NUM_WORKERS; i++) begin
            w_slotNext[i] = r_slot[i];
            case (r_slot[i])
                SL_IDLE:  if (worker_load[i]) w_slotNext[i] = SL_START;
                SL_START: w_slotNext[i] = SL_BUSY;
                SL_BUSY:  if (r_accepted[i]) w_slotNext[i] = SL_COOL;
                SL_COOL:  w_slotNext[i] = SL_IDLE;
                default:  w_slotNext[i] = SL_IDLE;
            endcase
        end

        case (r_state)
            S_RUN: begin
                if (w_fire && job_last) begin
                    w_stateNext = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_retired == r_issued) && !(|w_active)) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    w_stateNext   = S_RUN;
                    w_totalNext   = '0;
                    w_issuedNext  = '0;
                    w_retiredNext = '0;
                end
            end
            default: w_stateNext = S_RUN;
        endcase
    end

    // State, strobe and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_start    <= '0;
            r_accepted <= '0;
            r_total    <= '0;
            r_issued   <= '0;
            r_retired  <= '0;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_slot[i] <= SL_IDLE;
            end
        end else begin
            r_state    <= w_stateNext;
            r_start    <= worker_load;
            r_accepted <= w_retireGrant;
            r_total    <= w_totalNext;
            r_issued   <= w_issuedNext;
            r_retired  <= w_retiredNext;
            for (int i = 0; i < NUM_WORKERS; i++) begin
                r_slot[i] <= w_slotNext[i];
            end
        end
    end

    assign worker_start    = r_start;
    assign worker_accepted = r_accepted;
    assign total           = r_total;
    assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_machine_scheduler.sv
// Directed bench for machine_scheduler with two stub workers of
// configurable latency whose ready lingers one cycle after accepted.
module tb_machine_scheduler;

    localparam int NW = 2;
    localparam int PW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_last;
    logic          job_ready;
    logic [NW-1:0] worker_load;
    logic [NW-1:0] worker_start;
    logic [NW-1:0] worker_ready;
    logic [NW*PW-1:0] worker_presses;
    logic [NW-1:0] worker_accepted;
    logic          clear;
    logic [SW-1:0] total;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    // Stub worker state
    logic [NW-1:0] rdy;
    logic [PW-1:0] stubPress [NW];
    int            stubLat   [NW];
    int            cnt       [NW];
    bit            hold      [NW];

    // Observation state
    int cyc = 0;
    int curPresses;
    int curLat;
    bit sFire;
    bit sRst;
    logic [NW-1:0] sLoad, sStart, sAcc, prevReady;
    int loadLog[$];
    int accLog[$];
    int accCyc[$];
    int startCount;
    int stallCycles;
    int readyRise;
    int doneCyc;

    machine_scheduler #(
        .NUM_WORKERS       (NW),
        .MAX_NUM_PRESSES_W (PW),
        .SUM_W             (SW),
        .JOB_CNT_W         (12)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid       (job_valid),
        .job_last        (job_last),
        .job_ready       (job_ready),
        .worker_load     (worker_load),
        .worker_start    (worker_start),
        .worker_ready    (worker_ready),
        .worker_presses  (worker_presses),
        .worker_accepted (worker_accepted),
        .clear           (clear),
        .total           (total),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        loadLog.delete();
        accLog.delete();
        accCyc.delete();
        startCount  = 0;
        stallCycles = 0;
        readyRise   = -1;
        doneCyc     = -1;
    endtask

    // One clock: sample DUT strobes mid-cycle, then advance the stub workers.
    task automatic tick();
        @(negedge clk);
        sRst   = rst_n;
        sFire  = job_valid && job_ready;
        sLoad  = worker_load;
        sStart = worker_start;
        sAcc   = worker_accepted;
        if (job_valid && !job_ready) stallCycles++;
        for (int i = 0; i < NW; i++) begin
            if (sLoad[i]) begin
                loadLog.push_back(i);
                stubPress[i] = PW'(curPresses);
                stubLat[i]   = curLat;
            end
            if (sStart[i]) startCount++;
            if (sAcc[i]) begin
                accLog.push_back(i);
                accCyc.push_back(cyc);
            end
            if (worker_ready[i] && !prevReady[i] && readyRise < 0) readyRise = cyc;
        end
        prevReady = worker_ready;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NW; i++) begin
            if (!sRst) begin
                cnt[i] = 0; rdy[i] = 1'b0; hold[i] = 1'b0; stubPress[i] = '0;
            end else if (sStart[i]) begin
                cnt[i] = stubLat[i]; rdy[i] = 1'b0; hold[i] = 1'b0;
            end else if (hold[i]) begin
                rdy[i] = 1'b0; hold[i] = 1'b0;
            end else if (sAcc[i]) begin
                hold[i] = 1'b1;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) rdy[i] = 1'b1;
            end
            worker_presses[i*PW +: PW] = stubPress[i];
        end
        worker_ready = rdy;
        if (done && doneCyc < 0) doneCyc = cyc;
    endtask

    task automatic applyStimulus(input int presses, input int lat, input bit last);
        int n;
        n = 0;
        job_valid  = 1'b1;
        job_last   = last;
        curPresses = presses;
        curLat     = lat;
        sFire      = 1'b0;
        while (!sFire && n < 80) begin
            tick();
            n++;
        end
        if (!sFire) checkOutput("job fire timeout", 32'(sFire), 1);
        job_valid = 1'b0;
        job_last  = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, " done"}, 32'(done), 1);
    endtask

    task automatic clearStream(input string tag);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput({tag, " clear total"}, 32'(total), 0);
        checkOutput({tag, " clear done"}, 32'(done), 0);
        checkOutput({tag, " clear job_ready"}, 32'(job_ready), 1);
    endtask

    task automatic checkQuietOutputs(input string tag);
        checkOutput({tag, " job_ready"}, 32'(job_ready), 1);
        checkOutput({tag, " worker_load"}, 32'(worker_load), 0);
        checkOutput({tag, " worker_start"}, 32'(worker_start), 0);
        checkOutput({tag, " worker_accepted"}, 32'(worker_accepted), 0);
        checkOutput({tag, " total"}, 32'(total), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_last = 1'b0; clear = 1'b0;
        rdy = '0; prevReady = '0; worker_ready = '0; worker_presses = '0;
        curPresses = 0; curLat = 1;
        for (int i = 0; i < NW; i++) begin
            stubPress[i] = '0; stubLat[i] = 1; cnt[i] = 0; hold[i] = 1'b0;
        end
        clearLogs();

        // Reset state
        tick();
        tick();
        checkQuietOutputs("reset");
        rst_n = 1'b1;
        tick();

        // Three jobs on two workers; third waits for slot 0's cooldown
        clearLogs();
        applyStimulus(2, 10, 1'b0);
        applyStimulus(3, 10, 1'b0);
        applyStimulus(1, 10, 1'b1);
        checkOutput("t1 job_ready in drain", 32'(job_ready), 0);
        waitDone("t1");
        checkOutput("t1 total", 32'(total), 6);
        checkOutput("t1 start pulses", 32'(startCount), 3);
        checkOutput("t1 load count", 32'(loadLog.size()), 3);
        checkOutput("t1 job1 slot", 32'(loadLog[0]), 0);
        checkOutput("t1 job2 slot", 32'(loadLog[1]), 1);
        checkOutput("t1 job3 slot", 32'(loadLog[2]), 0);
        checkOutput("t1 stalled while full", 32'(stallCycles > 0), 1);
        checkOutput("t1 accept count", 32'(accLog.size()), 3);
        clearStream("t1");

        // Simultaneous ready with pointer at 1: slot 1 first
        clearLogs();
        applyStimulus(4, 11, 1'b0);
        applyStimulus(5, 10, 1'b1);
        waitDone("t2a");
        checkOutput("t2a total", 32'(total), 9);
        checkOutput("t2a accept count", 32'(accLog.size()), 2);
        checkOutput("t2a first winner", 32'(accLog[0]), 1);
        checkOutput("t2a second winner", 32'(accLog[1]), 0);
        checkOutput("t2a back-to-back", 32'(accCyc[1] - accCyc[0]), 1);
        clearStream("t2a");

        // Staggered ready with lingering ready: no double count
        clearLogs();
        applyStimulus(1, 10, 1'b0);
        applyStimulus(2, 10, 1'b1);
        waitDone("t2b");
        checkOutput("t2b total", 32'(total), 3);
        checkOutput("t2b accept count", 32'(accLog.size()), 2);
        checkOutput("t2b first winner", 32'(accLog[0]), 0);
        checkOutput("t2b second winner", 32'(accLog[1]), 1);
        clearStream("t2b");

        // Simultaneous ready with pointer at 0: slot 0 first
        clearLogs();
        applyStimulus(3, 11, 1'b0);
        applyStimulus(4, 10, 1'b1);
        waitDone("t2c");
        checkOutput("t2c total", 32'(total), 7);
        checkOutput("t2c first winner", 32'(accLog[0]), 0);
        checkOutput("t2c second winner", 32'(accLog[1]), 1);
        checkOutput("t2c back-to-back", 32'(accCyc[1] - accCyc[0]), 1);
        clearStream("t2c");

        // Wrap: 9 + 9 mod 16, with clear ignored while draining
        clearLogs();
        applyStimulus(9, 10, 1'b0);
        applyStimulus(9, 10, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("t5 clear in drain job_ready", 32'(job_ready), 0);
        checkOutput("t5 clear in drain done", 32'(done), 0);
        waitDone("t5");
        checkOutput("t5 wrapped total", 32'(total), 2);
        clearStream("t5");

        // Reset while two jobs are busy
        clearLogs();
        applyStimulus(7, 2, 1'b0);
        applyStimulus(3, 40, 1'b0);
        applyStimulus(3, 40, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("t6 total before reset", 32'(total), 7);
        checkOutput("t6 done before reset", 32'(done), 0);
        rst_n = 1'b0;
        tick();
        checkQuietOutputs("t6 after reset");
        rst_n = 1'b1;
        tick();

        // Fresh single-job stream with edge-accurate timing
        clearLogs();
        applyStimulus(5, 3, 1'b1);
        waitDone("t6b");
        checkOutput("t6b total", 32'(total), 5);
        checkOutput("t6b start pulses", 32'(startCount), 1);
        checkOutput("t6b accept count", 32'(accLog.size()), 1);
        checkOutput("t6b accept latency", 32'(accCyc[0] - readyRise), 1);
        checkOutput("t6b done latency", 32'(doneCyc - accCyc[0]), 2);
        clearStream("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
